// File: rtl/snn_fc_layer.sv
// Fully-connected SNN layer engine: y[j] = act(sat((sum_i x[i]*w[j][i]) >>> FRAC)).
// Optional argmax output `digit` is built only when SNN_ARGMAX_EN is defined.
module snn_fc_layer #(
  parameter int N_IN  = 784,
  parameter int N_OUT = 32,
  parameter int DW    = 8,
  parameter int FRAC  = 7,
  parameter int ACT   = 1,
  parameter int IA_W  = $clog2(N_IN),
  parameter int WA_W  = $clog2(N_IN*N_OUT),
  parameter int OA_W  = $clog2(N_OUT)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [IA_W-1:0] in_addr,
  input  logic [DW-1:0]   in_q,
  output logic [WA_W-1:0] w_addr,
  input  logic [DW-1:0]   w_q,
  output logic [OA_W-1:0] out_addr,
  output logic [DW-1:0]   out_data,
  output logic            out_we,
  output logic            busy,
  output logic            done
`ifdef SNN_ARGMAX_EN
  ,
  output logic [OA_W-1:0] digit
`endif
);

  localparam int AW = 2*DW + $clog2(N_IN);
  localparam logic signed [AW-1:0] C_MAX = AW'((2**(DW-1)) - 1);
  localparam logic signed [AW-1:0] C_MIN = ~C_MAX;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAC,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  state_t r_state, w_state_nxt;

  logic [IA_W-1:0]        r_i;
  logic [OA_W-1:0]        r_j;
  logic [WA_W-1:0]        r_waddr;
  logic signed [AW-1:0]   r_acc;

  logic                   w_last_i;
  logic                   w_last_j;
  logic signed [2*DW-1:0] w_prod;
  logic signed [AW-1:0]   w_acc_sum;
  logic signed [AW-1:0]   w_shift;
  logic signed [AW-1:0]   w_sat;
  logic [DW-1:0]          w_res;

  assign in_addr  = r_i;
  assign w_addr   = r_waddr;
  assign w_last_i = (r_i == IA_W'(N_IN - 1));
  assign w_last_j = (r_j == OA_W'(N_OUT - 1));

  assign w_prod    = (2*DW)'($signed(in_q)) * (2*DW)'($signed(w_q));
  assign w_acc_sum = r_acc + AW'(w_prod);
  assign w_shift   = w_acc_sum >>> FRAC;

  // Result is formed in DRAIN from the final sum so out_data is registered for WRITE.
  always_comb begin
    w_sat = w_shift;
    if (w_shift > C_MAX) begin
      w_sat = C_MAX;
    end else if (w_shift < C_MIN) begin
      w_sat = C_MIN;
    end
    w_res = w_sat[DW-1:0];
    if ((ACT == 1) && w_sat[AW-1]) begin
      w_res = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_MAC;
      end
      S_MAC: begin
        busy = 1'b1;
        if (w_last_i) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy        = 1'b1;
        w_state_nxt = S_WRITE;
      end
      S_WRITE: begin
        busy        = 1'b1;
        w_state_nxt = w_last_j ? S_DONE : S_MAC;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i      <= '0;
      r_j      <= '0;
      r_waddr  <= '0;
      r_acc    <= '0;
      out_addr <= '0;
      out_data <= '0;
      out_we   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_i     <= '0;
            r_j     <= '0;
            r_waddr <= '0;
            r_acc   <= '0;
          end
        end
        S_MAC: begin
          // Data for address i arrives one cycle later, so i=0 has nothing to add yet.
          if (r_i != '0) r_acc <= w_acc_sum;
          if (!w_last_i) begin
            r_i     <= r_i + IA_W'(1);
            r_waddr <= r_waddr + WA_W'(1);
          end
        end
        S_DRAIN: begin
          r_acc    <= w_acc_sum;
          out_we   <= 1'b1;
          out_addr <= r_j;
          out_data <= w_res;
        end
        S_WRITE: begin
          out_we <= 1'b0;
          r_acc  <= '0;
          r_i    <= '0;
          if (!w_last_j) begin
            r_j     <= r_j + OA_W'(1);
            r_waddr <= r_waddr + WA_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SNN_ARGMAX_EN
  logic signed [DW-1:0] r_max;
  logic [OA_W-1:0]      r_max_idx;
  logic                 w_greater;

  assign w_greater = ($signed(out_data) > r_max);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_max     <= {1'b1, {(DW-1){1'b0}}};
      r_max_idx <= '0;
      digit     <= '0;
    end else begin
      if ((r_state == S_IDLE) && start) begin
        r_max     <= {1'b1, {(DW-1){1'b0}}};
        r_max_idx <= '0;
      end else if (r_state == S_WRITE) begin
        if (w_greater) begin
          r_max     <= $signed(out_data);
          r_max_idx <= r_j;
        end
        // Last write folds in directly so digit is already valid in the DONE cycle.
        if (w_last_j) digit <= w_greater ? r_j : r_max_idx;
      end
    end
  end
`endif

endmodule

// File: tb/tb_snn_fc_layer.sv
// Bench for snn_fc_layer: two instances (identity and ReLU) share the same RAM/ROM contents
// and are checked against an arithmetic model of the layer. Define SNN_ARGMAX_EN to cover digit.
module tb_snn_fc_layer;
  localparam int N_IN  = 4;
  localparam int N_OUT = 2;
  localparam int DW    = 8;
  localparam int FRAC  = 7;
  localparam int IA_W  = $clog2(N_IN);
  localparam int WA_W  = $clog2(N_IN*N_OUT);
  localparam int OA_W  = $clog2(N_OUT);
  localparam int LAT   = N_IN + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] in_mem [N_IN];
  logic [DW-1:0] w_mem  [N_IN*N_OUT];

  logic [IA_W-1:0] in_addr_a, in_addr_r;
  logic [WA_W-1:0] w_addr_a, w_addr_r;
  logic [DW-1:0]   in_q_a, in_q_r, w_q_a, w_q_r;
  logic [OA_W-1:0] out_addr_a, out_addr_r;
  logic [DW-1:0]   out_data_a, out_data_r;
  logic            out_we_a, out_we_r, busy_a, busy_r, done_a, done_r;
`ifdef SNN_ARGMAX_EN
  logic [OA_W-1:0] digit_a, digit_r;
`endif

  always @(posedge clk) begin
    in_q_a <= in_mem[in_addr_a];
    w_q_a  <= w_mem[w_addr_a];
    in_q_r <= in_mem[in_addr_r];
    w_q_r  <= w_mem[w_addr_r];
  end

  snn_fc_layer #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .FRAC(FRAC), .ACT(0)) u_dut_id (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_addr(in_addr_a), .in_q(in_q_a), .w_addr(w_addr_a), .w_q(w_q_a),
    .out_addr(out_addr_a), .out_data(out_data_a), .out_we(out_we_a),
    .busy(busy_a), .done(done_a)
`ifdef SNN_ARGMAX_EN
    , .digit(digit_a)
`endif
  );

  snn_fc_layer #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .FRAC(FRAC), .ACT(1)) u_dut_relu (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_addr(in_addr_r), .in_q(in_q_r), .w_addr(w_addr_r), .w_q(w_q_r),
    .out_addr(out_addr_r), .out_data(out_data_r), .out_we(out_we_r),
    .busy(busy_r), .done(done_r)
`ifdef SNN_ARGMAX_EN
    , .digit(digit_r)
`endif
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: integer dot product, floor shift, saturate, optional ReLU.
  function automatic int model(input int j, input int act);
    int s;
    s = 0;
    for (int i = 0; i < N_IN; i++)
      s += int'($signed(in_mem[i])) * int'($signed(w_mem[j*N_IN + i]));
    s = s >>> FRAC;
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    if (act == 1 && s < 0) s = 0;
    return s;
  endfunction

  function automatic int model_argmax(input int act);
    int best, idx;
    best = model(0, act);
    idx  = 0;
    for (int j = 1; j < N_OUT; j++) begin
      if (model(j, act) > best) begin
        best = model(j, act);
        idx  = j;
      end
    end
    return idx;
  endfunction

  function automatic int all_out_a();
    return int'({in_addr_a, w_addr_a, out_addr_a, out_data_a, out_we_a, busy_a, done_a});
  endfunction

  function automatic int all_out_r();
    return int'({in_addr_r, w_addr_r, out_addr_r, out_data_r, out_we_r, busy_r, done_r});
  endfunction

  task automatic load(input int x0, input int w0, input int w1);
    for (int i = 0; i < N_IN; i++) begin
      in_mem[i]        = DW'(x0);
      w_mem[i]         = DW'(w0);
      w_mem[N_IN + i]  = DW'(w1);
    end
  endtask

  task automatic load_random();
    for (int i = 0; i < N_IN; i++) in_mem[i] = DW'($urandom_range(0, 255));
    for (int i = 0; i < N_IN*N_OUT; i++) w_mem[i] = DW'($urandom_range(0, 255));
  endtask

  task automatic do_run(input int mid_start);
    int n_a, n_r, done_t, busy_at_done;
    int a_addr[4], a_data[4], a_t[4], r_addr[4], r_data[4];
`ifdef SNN_ARGMAX_EN
    int dig_a, dig_r;
    dig_a = -1;
    dig_r = -1;
`endif
    n_a = 0;
    n_r = 0;
    done_t = -1;
    busy_at_done = -1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("busy_rise", int'(busy_a), 1);
    for (int k = 1; k <= 40 && done_t < 0; k++) begin
      if (k > 1) @(negedge clk);
      start = (mid_start != 0 && (k == 3 || k == 8)) ? 1'b1 : 1'b0;
      if (out_we_a) begin
        if (n_a < 4) begin
          a_addr[n_a] = int'(out_addr_a);
          a_data[n_a] = int'($signed(out_data_a));
          a_t[n_a]    = k;
        end
        n_a++;
      end
      if (out_we_r) begin
        if (n_r < 4) begin
          r_addr[n_r] = int'(out_addr_r);
          r_data[n_r] = int'($signed(out_data_r));
        end
        n_r++;
      end
      if (done_a) begin
        done_t = k;
        busy_at_done = int'(busy_a);
`ifdef SNN_ARGMAX_EN
        dig_a = int'(digit_a);
        dig_r = int'(digit_r);
`endif
      end
    end
    start = 1'b0;
    chk("done_time", done_t, N_OUT*LAT + 1);
    chk("busy_at_done", busy_at_done, 0);
    chk("writes_id", n_a, N_OUT);
    chk("writes_relu", n_r, N_OUT);
    for (int j = 0; j < N_OUT && j < n_a && j < 4; j++) begin
      chk("addr_id", a_addr[j], j);
      chk("data_id", a_data[j], model(j, 0));
      chk("we_time", a_t[j], (j + 1) * LAT);
    end
    for (int j = 0; j < N_OUT && j < n_r && j < 4; j++) begin
      chk("addr_relu", r_addr[j], j);
      chk("data_relu", r_data[j], model(j, 1));
    end
`ifdef SNN_ARGMAX_EN
    chk("digit_id", dig_a, model_argmax(0));
    chk("digit_relu", dig_r, model_argmax(1));
`endif
    @(negedge clk);
    chk("idle_we", int'(out_we_a | out_we_r), 0);
    chk("idle_done", int'(done_a | done_r), 0);
    chk("hold_data", int'($signed(out_data_a)), model(N_OUT - 1, 0));
    chk("hold_addr", int'(out_addr_r), N_OUT - 1);
`ifdef SNN_ARGMAX_EN
    chk("digit_hold", int'(digit_a), model_argmax(0));
`endif
  endtask

  task automatic reset_mid_run();
    int ev;
    ev = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_id", all_out_a(), 0);
    chk("rst_mid_relu", all_out_r(), 0);
`ifdef SNN_ARGMAX_EN
    chk("rst_mid_digit", int'(digit_a), 0);
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_we_a || out_we_r || done_a || done_r || busy_a) ev++;
    end
    chk("rst_abort", ev, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    load(0, 0, 0);
    #1;
    chk("reset_id", all_out_a(), 0);
    chk("reset_relu", all_out_r(), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    load(8'h7F, 8'h10, 8'hF0);      // 63 and -64 (ReLU -> 0)
    do_run(0);
    load(8'h7F, 8'h7F, 8'h80);      // positive and negative saturation, start pulsed mid-run
    do_run(1);
    load(8'h7F, 8'h40, 8'h40);      // tie: lowest index wins
    do_run(0);
    reset_mid_run();
    load(8'h7F, 8'h10, 8'hF0);
    do_run(0);
    for (int r = 0; r < 8; r++) begin
      load_random();
      do_run(int'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/snn_fc_layer.md
Name: snn_fc_layer

Overview:
- Parametrised fully-connected layer engine for the SNN digit classifier; generalises the fixed input→hidden core to any layer size.
- On `start`, computes, for each output neuron j, the value y[j] = act(sat(Σ x[i]·w[j][i] >> FRAC)).
- Reads activations from an input RAM and weights from a ROM, and writes results to an output RAM.
- Instances are chained to build input→hidden and hidden→output stages.

Parameters:
N_IN, 784, number of inputs per neuron
N_OUT, 32, number of output neurons
DW, 8, signed data/weight width (two's complement)
FRAC, 7, fractional bits of the data format (Q1.7 at defaults)
ACT, 1, activation: 0 = identity, 1 = ReLU
IA_W, $clog2(N_IN), input address width
WA_W, $clog2(N_IN*N_OUT), weight address width
OA_W, $clog2(N_OUT), output address width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request to run the layer; ignored while busy=1
in_addr  out  IA_W  input RAM read address
in_q  in  DW  input RAM data, valid 1 cycle after in_addr
w_addr  out  WA_W  weight ROM address (j*N_IN + i)
w_q  in  DW  weight ROM data, valid 1 cycle after w_addr
out_addr  out  OA_W  output RAM write address
out_data  out  DW  output RAM write data
out_we  out  1  output RAM write enable, one cycle per neuron
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse when the last neuron has been written

Behaviour:
- Reset values: in_addr=0, w_addr=0, out_addr=0, out_data=0, out_we=0, busy=0, done=0; FSM=IDLE; accumulator=0.
- Clock/reset: single clock domain; async active-low reset (rst_n) forces IDLE at any time.
  - Reset mid-run aborts the run: no further out_we and no done.
- FSM states: IDLE, MAC, DRAIN, WRITE, DONE.
- IDLE: on start=1, go to MAC.
  - Clear i, j, w_addr and acc.
  - busy goes high in the next cycle.
- MAC: each cycle, drive in_addr=i and w_addr=j*N_IN+i.
  - Compute w_addr with a running counter, not a multiplier.
  - Accumulate the product from the previous cycle's addresses (1-cycle read latency). The first MAC cycle of a neuron accumulates nothing.
  - When i=N_IN-1, go to DRAIN.
- DRAIN: accumulate the final product, then go to WRITE.
- WRITE: assert out_we=1 with out_addr=j and out_data=result.
  - Clear acc and i.
  - If j=N_OUT-1, go to DONE; otherwise increment j and go to MAC.
- DONE: assert done=1 for one cycle, busy=0, then go to IDLE.
- Latency: N_OUT*(N_IN+2) cycles from the first MAC cycle to the last out_we; done follows 1 cycle later.
- start while busy=1 has no effect. start in the DONE cycle has no effect; start is accepted only in IDLE.
- Arithmetic:
  - Product is 2*DW signed.
  - Accumulator is 2*DW + $clog2(N_IN) bits signed, with no overflow possible.
  - Result = acc >>> FRAC (arithmetic shift, truncation toward −∞).
  - The result is then saturated to the range [−2^(DW−1), 2^(DW−1)−1].
  - If ACT=1, negative results are clamped to 0 after saturation.
- out_data and out_addr hold their last written values outside WRITE; out_we is the only qualifier.

Optional Feature:
- Macro: SNN_ARGMAX_EN.
- When defined:
  - Adds output port `digit` (out, OA_W bits, reset 0).
  - Tracks the running maximum of the post-activation results across WRITE cycles. A strictly greater value replaces the maximum, so ties keep the lowest index.
  - Updates `digit` in the DONE cycle so it is valid while done=1; it holds until the next DONE.
  - The running max resets at start.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Bench parameters: N_IN=4, N_OUT=2, DW=8, FRAC=7.
- Inputs 0x7F ×4, neuron-0 weights 0x10 ×4 → out_we at out_addr=0 with out_data=0x3F (8128>>>7=63).
- Same inputs, neuron-1 weights 0xF0 ×4 → ACT=1 gives out_data=0x00; ACT=0 gives out_data=0xC0 (−64).
- Weights 0x7F, inputs 0x7F → sum 64516>>>7=504 → out_data saturates to 0x7F; neuron-1 weights 0x80 with inputs 0x7F, ACT=0 → 0x80.
- Timing check → first out_we exactly 6 cycles after the first MAC cycle, second after 12; done one cycle after the second out_we. start pulsed mid-run → ignored, exactly 2 writes.
- rst_n asserted during neuron 0 MAC → all outputs 0 immediately, no out_we or done. A new start after release runs cleanly with correct values.
- SNN_ARGMAX_EN with N_OUT=3 and results {0x10, 0x40, 0x40} → digit=1 during done.
